// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: owner codes,
// arbiter states and the round-robin pick helper.
package mem_pkg;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_LD   = 2'd1,
      OWNER_CPU  = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OWN_LD  = 2'd1,
      ST_OWN_CPU = 2'd2,
      ST_TURN    = 2'd3
   } arb_state_e;

   // Winner among eligible requesters; a tie goes to
   // whoever did not own the bus last.
   function automatic owner_e arb_pick(
      input logic   ld_el,
      input logic   cpu_el,
      input owner_e last
   );
      if (ld_el && cpu_el) begin
         if (last == OWNER_LD) return OWNER_CPU;
         return OWNER_LD;
      end
      if (ld_el) return OWNER_LD;
      if (cpu_el) return OWNER_CPU;
      return OWNER_NONE;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Arbiter handshake bundle: requests, observed bus enables,
// grants. master = arbiter side, slave = requester/bus side.
interface mem_arbiter_if;
   import mem_pkg::*;

   logic   req_ld;
   logic   req_cpu;
   logic   rom_mapped;
   logic   bus_rd_en;
   logic   bus_wr_en;
   logic   bus_ready;
   logic   gnt_ld;
   logic   gnt_cpu;
   owner_e owner;
   logic   preempt;

   modport master (
      input  req_ld,
      input  req_cpu,
      input  rom_mapped,
      input  bus_rd_en,
      input  bus_wr_en,
      input  bus_ready,
      output gnt_ld,
      output gnt_cpu,
      output owner,
      output preempt
   );

   modport slave (
      output req_ld,
      output req_cpu,
      output rom_mapped,
      output bus_rd_en,
      output bus_wr_en,
      output bus_ready,
      input  gnt_ld,
      input  gnt_cpu,
      input  owner,
      input  preempt
   );

endinterface

// File: rtl/mem_arbiter_hold_counter.sv
// Saturating owned-cycle counter. Ports: clk, rst (sync),
// clr_i, inc_i, sat_o (count has reached HOLD_MAX).
module hold_counter #(
   parameter int unsigned HOLD_MAX = 64,
   parameter int unsigned CNT_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic sat_o
);

   localparam logic [CNT_W-1:0] MAX = CNT_W'(HOLD_MAX);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q >= MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Two-way shared memory bus arbiter (loader / CPU).
// Ports: clk, rst (sync, active-high), arb (master modport).
module mem_arbiter #(
   parameter int unsigned HOLD_MAX = 64,
   parameter int unsigned CNT_W    = 8
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master arb
);
   import mem_pkg::*;

   localparam bit PRE_EN = (HOLD_MAX != 0);

   arb_state_e state_q;
   arb_state_e state_d;
   owner_e     last_q;
   owner_e     last_d;
   owner_e     owner_q;
   owner_e     pick;
   logic       gnt_ld_q;
   logic       gnt_cpu_q;
   logic       pre_q;
   logic       pre_d;
   logic       inflight_q;
   logic       inflight_d;
   logic       rdy_q;
   logic       rdy_d;

   logic en;
   logic clr;
   logic busy;
   logic ld_el;
   logic cpu_el;
   logic sat;
   logic own_nxt;

   // Undriven (z/x) shared enables read as idle.
   assign en = (arb.bus_rd_en === 1'b1) ||
               (arb.bus_wr_en === 1'b1);

   // rdy_q: ready was seen in the last enabled cycle.
   // An access is done once enables are low and ready
   // has been seen, either then or in that last cycle.
   assign clr  = !en && (rdy_q || arb.bus_ready);
   assign busy = en || (inflight_q && !clr);

   assign inflight_d = en || (inflight_q && !clr);
   assign rdy_d      = en && arb.bus_ready;

   assign ld_el  = arb.req_ld;
   assign cpu_el = arb.req_cpu && arb.rom_mapped;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      pre_d   = 1'b0;
      pick    = arb_pick(ld_el, cpu_el, last_q);
      unique case (state_q)
         ST_IDLE, ST_TURN: begin
            unique case (pick)
               OWNER_LD:  state_d = ST_OWN_LD;
               OWNER_CPU: state_d = ST_OWN_CPU;
               default:   state_d = ST_IDLE;
            endcase
         end
         ST_OWN_LD: begin
            if (!busy) begin
               if (!ld_el) begin
                  state_d = ST_TURN;
                  last_d  = OWNER_LD;
               end else if (PRE_EN && sat && cpu_el) begin
                  state_d = ST_TURN;
                  last_d  = OWNER_LD;
                  pre_d   = 1'b1;
               end
            end
         end
         ST_OWN_CPU: begin
            // Losing rom_mapped counts as a release.
            if (!busy) begin
               if (!cpu_el) begin
                  state_d = ST_TURN;
                  last_d  = OWNER_CPU;
               end else if (PRE_EN && sat && ld_el) begin
                  state_d = ST_TURN;
                  last_d  = OWNER_CPU;
                  pre_d   = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign own_nxt = (state_d == ST_OWN_LD) ||
                    (state_d == ST_OWN_CPU);

   // Counts owned cycles including the current one, so
   // the first granted cycle already reads 1.
   hold_counter #(
      .HOLD_MAX (HOLD_MAX),
      .CNT_W    (CNT_W)
   ) u_hold (
      .clk   (clk),
      .rst   (rst),
      .clr_i (!own_nxt),
      .inc_i (own_nxt),
      .sat_o (sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         last_q     <= OWNER_CPU;
         owner_q    <= OWNER_NONE;
         gnt_ld_q   <= 1'b0;
         gnt_cpu_q  <= 1'b0;
         pre_q      <= 1'b0;
         inflight_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         pre_q      <= pre_d;
         inflight_q <= inflight_d;
         rdy_q      <= rdy_d;
         gnt_ld_q   <= (state_d == ST_OWN_LD);
         gnt_cpu_q  <= (state_d == ST_OWN_CPU);
         if (state_d == ST_OWN_LD) begin
            owner_q <= OWNER_LD;
         end else if (state_d == ST_OWN_CPU) begin
            owner_q <= OWNER_CPU;
         end else begin
            owner_q <= OWNER_NONE;
         end
      end
   end

   assign arb.gnt_ld  = gnt_ld_q;
   assign arb.gnt_cpu = gnt_cpu_q;
   assign arb.owner   = owner_q;
   assign arb.preempt = pre_q;

   a_gnt_excl: assert property (
      @(posedge clk) disable iff (rst)
      !(gnt_ld_q && gnt_cpu_q)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a random
// run against a cycle-level behavioural model.
module tb_mem_arbiter;

   localparam int HM = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mem_arbiter_if arb();

   mem_arbiter #(
      .HOLD_MAX (HM),
      .CNT_W    (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .arb (arb)
   );

   int checks = 0;
   int errors = 0;

   // Model: who owns (0 none,1 ld,2 cpu), who owned last,
   // owned cycles so far, preempt pulse, unanswered access.
   int m_own  = 0;
   int m_last = 2;
   int m_held = 0;
   bit m_pre  = 0;
   bit m_owe  = 0;

   // Previous-cycle facts for the random invariants.
   bit p_en;
   bit p_rst;
   bit p_gl;
   bit p_gc;

   function automatic logic [4:0] m_vec();
      logic [1:0] o;
      o = 2'(m_own);
      return {m_own == 1, m_own == 2, o, m_pre};
   endfunction

   function automatic logic [4:0] d_vec();
      return {arb.gnt_ld, arb.gnt_cpu,
              2'(arb.owner), arb.preempt};
   endfunction

   task automatic tick();
      bit en;
      bit busy;
      bit ld;
      bit cpu;
      bit rel;
      bit oth;
      int n_own;
      int n_last;
      int n_held;
      bit n_pre;
      bit n_owe;
      en = (arb.bus_rd_en === 1'b1) ||
           (arb.bus_wr_en === 1'b1);
      busy = en || (m_owe && !arb.bus_ready);
      n_owe = en ? !arb.bus_ready
                 : (m_owe && !arb.bus_ready);
      ld  = arb.req_ld;
      cpu = arb.req_cpu && arb.rom_mapped;
      n_own  = m_own;
      n_last = m_last;
      n_held = m_held;
      n_pre  = 0;
      if (m_own == 0) begin
         if (ld && cpu) n_own = (m_last == 1) ? 2 : 1;
         else if (ld) n_own = 1;
         else if (cpu) n_own = 2;
         else n_own = 0;
         n_held = (n_own != 0) ? 1 : 0;
      end else begin
         rel = (m_own == 1) ? !ld : !cpu;
         oth = (m_own == 1) ? cpu : ld;
         if (!busy && rel) begin
            n_own = 0;
            n_last = m_own;
            n_held = 0;
         end else if (!busy && HM != 0 &&
                      m_held >= HM && oth) begin
            n_own = 0;
            n_last = m_own;
            n_held = 0;
            n_pre = 1;
         end else begin
            n_held = m_held + 1;
         end
      end
      p_en  = en;
      p_rst = rst;
      p_gl  = arb.gnt_ld;
      p_gc  = arb.gnt_cpu;
      @(posedge clk);
      if (rst) begin
         m_own = 0;
         m_last = 2;
         m_held = 0;
         m_pre = 0;
         m_owe = 0;
      end else begin
         m_own = n_own;
         m_last = n_last;
         m_held = n_held;
         m_pre = n_pre;
         m_owe = n_owe;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1;
      arb.req_ld = 0;
      arb.req_cpu = 0;
      arb.rom_mapped = 0;
      arb.bus_rd_en = 0;
      arb.bus_wr_en = 0;
      arb.bus_ready = 0;
      tick();
      tick();
      checks++;
      if (d_vec() !== 5'b0) begin
         errors++;
         $display("FAIL reset_outs got %b exp %b",
                  d_vec(), 5'b0);
      end
      rst = 0;
      tick();
      checks++;
      if (d_vec() !== 5'b0) begin
         errors++;
         $display("FAIL idle_outs got %b exp %b",
                  d_vec(), 5'b0);
      end
   endtask

   task automatic test_loader_only();
      arb.req_ld = 1;
      arb.req_cpu = 1;
      tick();
      checks++;
      if (arb.gnt_ld !== 1'b1 || arb.owner !== 2'd1) begin
         errors++;
         $display("FAIL ld_grant got %b/%0d exp 1/1",
                  arb.gnt_ld, arb.owner);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (d_vec() !== 5'b10010) begin
            errors++;
            $display("FAIL ld_only got %b exp %b",
                     d_vec(), 5'b10010);
         end
      end
   endtask

   task automatic test_release_inflight();
      arb.req_ld = 0;
      arb.bus_rd_en = 1;
      arb.rom_mapped = 1;
      for (int i = 0; i < 4; i++) begin
         arb.bus_ready = (i == 3);
         tick();
         checks++;
         if (arb.gnt_ld !== 1'b1) begin
            errors++;
            $display("FAIL rd_hold got %b exp 1",
                     arb.gnt_ld);
         end
      end
      arb.bus_rd_en = 0;
      arb.bus_ready = 0;
      tick();
      checks++;
      if (d_vec() !== 5'b0) begin
         errors++;
         $display("FAIL rel_turn got %b exp %b",
                  d_vec(), 5'b0);
      end
      tick();
      checks++;
      if (d_vec() !== 5'b01100) begin
         errors++;
         $display("FAIL cpu_after got %b exp %b",
                  d_vec(), 5'b01100);
      end
   endtask

   task automatic test_late_ready();
      arb.bus_wr_en = 1;
      tick();
      arb.bus_wr_en = 0;
      arb.req_cpu = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (arb.gnt_cpu !== 1'b1) begin
            errors++;
            $display("FAIL late_hold got %b exp 1",
                     arb.gnt_cpu);
         end
      end
      arb.bus_ready = 1;
      tick();
      arb.bus_ready = 0;
      checks++;
      if (d_vec() !== 5'b0) begin
         errors++;
         $display("FAIL late_rel got %b exp %b",
                  d_vec(), 5'b0);
      end
      tick();
   endtask

   task automatic test_zbus();
      arb.req_ld = 1;
      tick();
      arb.req_ld = 0;
      arb.bus_rd_en = 1'bz;
      arb.bus_wr_en = 1'bx;
      tick();
      checks++;
      if (d_vec() !== 5'b0 || d_vec() !== m_vec()) begin
         errors++;
         $display("FAIL z_idle got %b exp %b",
                  d_vec(), m_vec());
      end
      arb.bus_rd_en = 0;
      arb.bus_wr_en = 0;
      tick();
   endtask

   task automatic test_preempt();
      logic [4:0] exp;
      int ph;
      rst = 1;
      tick();
      rst = 0;
      arb.req_ld = 1;
      arb.req_cpu = 1;
      arb.rom_mapped = 1;
      for (int i = 0; i < 30; i++) begin
         tick();
         ph = i % 10;
         if (ph < 4) exp = 5'b10010;
         else if (ph == 4) exp = 5'b00001;
         else if (ph < 9) exp = 5'b01100;
         else exp = 5'b00001;
         checks++;
         if (d_vec() !== exp) begin
            errors++;
            $display("FAIL rr_%0d got %b exp %b",
                     i, d_vec(), exp);
         end
      end
   endtask

   task automatic test_hold_write();
      tick();
      arb.bus_wr_en = 1;
      for (int i = 0; i < 10; i++) begin
         arb.bus_ready = (i == 9);
         tick();
         checks++;
         if (d_vec() !== 5'b10010) begin
            errors++;
            $display("FAIL wr_hold got %b exp %b",
                     d_vec(), 5'b10010);
         end
      end
      arb.bus_wr_en = 0;
      arb.bus_ready = 0;
      tick();
      checks++;
      if (d_vec() !== 5'b00001) begin
         errors++;
         $display("FAIL wr_pre got %b exp %b",
                  d_vec(), 5'b00001);
      end
      tick();
      checks++;
      if (d_vec() !== 5'b01100) begin
         errors++;
         $display("FAIL wr_next got %b exp %b",
                  d_vec(), 5'b01100);
      end
   endtask

   task automatic test_rst_mid();
      arb.bus_wr_en = 1;
      tick();
      rst = 1;
      arb.bus_wr_en = 0;
      tick();
      checks++;
      if (d_vec() !== 5'b0) begin
         errors++;
         $display("FAIL rst_mid got %b exp %b",
                  d_vec(), 5'b0);
      end
      rst = 0;
      tick();
      checks++;
      if (arb.gnt_ld !== 1'b1 || arb.gnt_cpu !== 1'b0) begin
         errors++;
         $display("FAIL rst_ld got %b%b exp 10",
                  arb.gnt_ld, arb.gnt_cpu);
      end
   endtask

   task automatic test_random();
      int acc_left = 0;
      bit is_wr = 0;
      bit late = 0;
      bit late_pend = 0;
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(0, 7) == 0)
            arb.req_ld = ~arb.req_ld;
         if ($urandom_range(0, 7) == 0)
            arb.req_cpu = ~arb.req_cpu;
         if ($urandom_range(0, 63) == 0)
            arb.rom_mapped = ~arb.rom_mapped;
         rst = ($urandom_range(0, 1999) == 0);
         arb.bus_ready = 0;
         arb.bus_rd_en = 0;
         arb.bus_wr_en = 0;
         if (late_pend) begin
            arb.bus_ready = 1;
            late_pend = 0;
         end else if (acc_left == 0 &&
                      (arb.gnt_ld || arb.gnt_cpu) &&
                      $urandom_range(0, 2) == 0) begin
            acc_left = $urandom_range(1, 4);
            is_wr = 1'($urandom_range(0, 1));
            late = ($urandom_range(0, 3) == 0);
         end
         if (acc_left > 0) begin
            arb.bus_rd_en = !is_wr;
            arb.bus_wr_en = is_wr;
            if (acc_left == 1) begin
               if (late) late_pend = 1;
               else arb.bus_ready = 1;
            end
            acc_left--;
         end
         if (rst) begin
            acc_left = 0;
            late_pend = 0;
            arb.bus_rd_en = 0;
            arb.bus_wr_en = 0;
            arb.bus_ready = 0;
         end
         tick();
         checks++;
         if (d_vec() !== m_vec()) begin
            errors++;
            $display("FAIL rnd_%0d got %b exp %b",
                     c, d_vec(), m_vec());
         end
         checks++;
         if ((arb.gnt_ld & arb.gnt_cpu) !== 1'b0) begin
            errors++;
            $display("FAIL rnd_excl_%0d got %b%b exp !11",
                     c, arb.gnt_ld, arb.gnt_cpu);
         end
         if (p_en && !p_rst) begin
            checks++;
            if ({arb.gnt_ld, arb.gnt_cpu} !==
                {p_gl, p_gc}) begin
               errors++;
               $display("FAIL rnd_hold_%0d got %b%b exp %b%b",
                        c, arb.gnt_ld, arb.gnt_cpu,
                        p_gl, p_gc);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_loader_only();
      test_release_inflight();
      test_late_ready();
      test_zbus();
      test_preempt();
      test_hold_write();
      test_rst_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
